// File: rtl/mac27_chain_slice_pkg.sv
// Shared constants and helpers for the mac27 chain slice.
package mac27_pkg;

  localparam int MAX_OPERAND = 27;
  localparam int ACC_WIDTH   = 64;

  localparam int ENA_IN   = 0;
  localparam int ENA_PIPE = 1;
  localparam int ENA_OUT  = 2;

  function automatic int mac27_latency(input int input_pipe, input int second_pipe);
    return 2 + input_pipe + second_pipe;
  endfunction

endpackage

// File: rtl/mac27_chain_slice_if.sv
// Operand, enable and result bundle of one mac27 slice.
// MAC27_SCANOUT_EN adds the registered ay operand as scanout.
interface mac27_chain_slice_if #(
  parameter int AX_WIDTH       = 27,
  parameter int AY_WIDTH       = 27,
  parameter int RESULT_A_WIDTH = 64,
  parameter int CHAIN_WIDTH    = 64
);

  logic [2:0]                ena;
  logic [AX_WIDTH-1:0]       ax;
  logic [AY_WIDTH-1:0]       ay;
  logic [CHAIN_WIDTH-1:0]    chainin;
  logic [RESULT_A_WIDTH-1:0] resulta;
  logic [CHAIN_WIDTH-1:0]    chainout;

`ifdef MAC27_SCANOUT_EN
  logic [AY_WIDTH-1:0]       scanout;

  modport master (output ena, ax, ay, chainin, input resulta, chainout, scanout);
  modport slave  (input ena, ax, ay, chainin, output resulta, chainout, scanout);
`else
  modport master (output ena, ax, ay, chainin, input resulta, chainout);
  modport slave  (input ena, ax, ay, chainin, output resulta, chainout);
`endif

endinterface

// File: rtl/mac27_chain_slice_pipe_reg.sv
// Register with synchronous clear and clock enable; BYPASS=1 makes it a wire.
module mac27_pipe_reg #(
  parameter int WIDTH  = 64,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (BYPASS) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ clr ^ en;
    assign q = d;
  end else begin : g_reg
    always_ff @(posedge clk) begin
      if (clr)
        q <= '0;
      else if (en)
        q <= d;
    end
  end

endmodule

// File: rtl/mac27_chain_slice.sv
// Signed 27x27 multiply with optional pipeline stages and a 64-bit cascade adder.
// Define MAC27_SCANOUT_EN to expose the registered ay operand on bus.scanout.
module mac27_chain_slice
  import mac27_pkg::*;
#(
  parameter int AX_WIDTH           = 27,
  parameter int AY_WIDTH           = 27,
  parameter int RESULT_A_WIDTH     = 64,
  parameter int CHAIN_WIDTH        = 64,
  parameter int INPUT_PIPELINE_EN  = 0,
  parameter int SECOND_PIPELINE_EN = 1,
  parameter int USE_CHAINADDER     = 0
) (
  input logic clk,
  input logic clr,
  mac27_chain_slice_if.slave bus
);

  localparam int PROD_WIDTH = AX_WIDTH + AY_WIDTH;

  if (AX_WIDTH < 1 || AX_WIDTH > MAX_OPERAND || AY_WIDTH < 1 || AY_WIDTH > MAX_OPERAND ||
      RESULT_A_WIDTH < 1 || RESULT_A_WIDTH > ACC_WIDTH) begin : g_bad_width
    $error("mac27_chain_slice: operand width above 27 or result width above 64");
  end

  logic [AX_WIDTH-1:0]          ax_q;
  logic [AY_WIDTH-1:0]          ay_q;
  logic signed [AX_WIDTH-1:0]   ax_s;
  logic signed [AY_WIDTH-1:0]   ay_s;
  logic signed [PROD_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]         prod_ext;
  logic [ACC_WIDTH-1:0]         pipe1_q;
  logic [ACC_WIDTH-1:0]         pipe2_q;
  logic [ACC_WIDTH-1:0]         chain_ext;
  logic [ACC_WIDTH-1:0]         sum;
  logic [ACC_WIDTH-1:0]         out_q;

  mac27_pipe_reg #(.WIDTH(AX_WIDTH), .BYPASS(1'b0)) u_ax_reg (
    .clk(clk), .clr(clr), .en(bus.ena[ENA_IN]), .d(bus.ax), .q(ax_q)
  );

  mac27_pipe_reg #(.WIDTH(AY_WIDTH), .BYPASS(1'b0)) u_ay_reg (
    .clk(clk), .clr(clr), .en(bus.ena[ENA_IN]), .d(bus.ay), .q(ay_q)
  );

  // Operands are widened to the full product width before multiplying so no bits are lost.
  assign ax_s     = ax_q;
  assign ay_s     = ay_q;
  assign prod     = PROD_WIDTH'(ax_s) * PROD_WIDTH'(ay_s);
  assign prod_ext = ACC_WIDTH'(prod);

  mac27_pipe_reg #(.WIDTH(ACC_WIDTH), .BYPASS(INPUT_PIPELINE_EN == 0)) u_pipe1 (
    .clk(clk), .clr(clr), .en(bus.ena[ENA_PIPE]), .d(prod_ext), .q(pipe1_q)
  );

  mac27_pipe_reg #(.WIDTH(ACC_WIDTH), .BYPASS(SECOND_PIPELINE_EN == 0)) u_pipe2 (
    .clk(clk), .clr(clr), .en(bus.ena[ENA_PIPE]), .d(pipe1_q), .q(pipe2_q)
  );

  assign chain_ext = ACC_WIDTH'(signed'(bus.chainin));
  assign sum       = pipe2_q + ((USE_CHAINADDER != 0) ? chain_ext : '0);

  mac27_pipe_reg #(.WIDTH(ACC_WIDTH), .BYPASS(1'b0)) u_out_reg (
    .clk(clk), .clr(clr), .en(bus.ena[ENA_OUT]), .d(sum), .q(out_q)
  );

  assign bus.resulta  = out_q[RESULT_A_WIDTH-1:0];
  assign bus.chainout = CHAIN_WIDTH'(signed'(out_q));

`ifdef MAC27_SCANOUT_EN
  assign bus.scanout = ay_q;
`endif

endmodule

// File: tb/tb_mac27_chain_slice.sv
// Directed bench for mac27_chain_slice: default, chain-adder, latency-sweep and 4-slice chain builds.
module tb_mac27_chain_slice;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic chain_go = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mac27_chain_slice_if b0 ();
  mac27_chain_slice_if b1 ();
  mac27_chain_slice_if b2 ();
  mac27_chain_slice_if b3 ();
  mac27_chain_slice_if ci[4] ();

  mac27_chain_slice dut_def (.clk(clk), .clr(clr), .bus(b0));

  mac27_chain_slice #(.USE_CHAINADDER(1)) dut_chn (.clk(clk), .clr(clr), .bus(b1));

  mac27_chain_slice #(.INPUT_PIPELINE_EN(0), .SECOND_PIPELINE_EN(0)) dut_p00 (
    .clk(clk), .clr(clr), .bus(b2));

  mac27_chain_slice #(.INPUT_PIPELINE_EN(1), .SECOND_PIPELINE_EN(1)) dut_p11 (
    .clk(clk), .clr(clr), .bus(b3));

  // Four slices with no pipeline stages, each feeding the next one's chainin.
  for (genvar g = 0; g < 4; g++) begin : g_chain
    assign ci[g].ena = 3'b111;
    assign ci[g].ax  = chain_go ? 27'(g + 1) : '0;
    assign ci[g].ay  = chain_go ? 27'(1) : '0;
    if (g == 0) begin : g_head
      assign ci[g].chainin = '0;
    end else begin : g_link
      assign ci[g].chainin = ci[g-1].chainout;
    end
    mac27_chain_slice #(.INPUT_PIPELINE_EN(0), .SECOND_PIPELINE_EN(0), .USE_CHAINADDER(1))
      u_slice (.clk(clk), .clr(clr), .bus(ci[g]));
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [2:0] e,
                               input longint a, input longint b, input longint c);
    case (which)
      0: begin b0.ena = e; b0.ax = 27'(a); b0.ay = 27'(b); b0.chainin = 64'(c); end
      1: begin b1.ena = e; b1.ax = 27'(a); b1.ay = 27'(b); b1.chainin = 64'(c); end
      2: begin b2.ena = e; b2.ax = 27'(a); b2.ay = 27'(b); b2.chainin = 64'(c); end
      default: begin b3.ena = e; b3.ax = 27'(a); b3.ay = 27'(b); b3.chainin = 64'(c); end
    endcase
  endtask

  initial begin
    int first0;
    int first3;

    for (int k = 0; k < 4; k++) applyStimulus(k, 3'b111, 0, 0, 0);

    // Reset state
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    checkOutput("reset_def_resulta", b0.resulta, 64'd0);
    checkOutput("reset_def_chainout", b0.chainout, 64'd0);
    checkOutput("reset_chn_resulta", b1.resulta, 64'd0);
    checkOutput("reset_p11_resulta", b3.resulta, 64'd0);

    // 3 x -5 with default latency 3
    applyStimulus(0, 3'b111, 3, -5, 0);
    tick(2);
    checkOutput("basic_cycle2", b0.resulta, 64'd0);
    tick(1);
    checkOutput("basic_cycle3", b0.resulta, -64'sd15);
    tick(2);
    checkOutput("basic_hold", b0.resulta, -64'sd15);

    // Operand extremes
    applyStimulus(0, 3'b111, -67108864, -67108864, 0);
    tick(3);
    checkOutput("ext_negneg", b0.resulta, 64'd4503599627370496);
    applyStimulus(0, 3'b111, -67108864, 67108863, 0);
    tick(3);
    checkOutput("ext_negpos", b0.resulta, -64'sd4503599560261632);
    checkOutput("ext_negpos_chainout", b0.chainout, -64'sd4503599560261632);

    // Chain adder on vs off
    applyStimulus(0, 3'b111, 2, 7, 100);
    applyStimulus(1, 3'b111, 2, 7, 100);
    tick(3);
    checkOutput("chain_on_resulta", b1.resulta, 64'd114);
    checkOutput("chain_on_chainout", b1.chainout, 64'd114);
    checkOutput("chain_off_resulta", b0.resulta, 64'd14);

    // Modulo-2^64 wrap
    applyStimulus(1, 3'b111, 1, 1, 64'h7FFF_FFFF_FFFF_FFFF);
    tick(3);
    checkOutput("wrap", b1.resulta, 64'h8000_0000_0000_0000);

    // Output enable low freezes result while upstream advances
    applyStimulus(0, 3'b111, 6, 7, 0);
    tick(3);
    checkOutput("ena_load", b0.resulta, 64'd42);
    applyStimulus(0, 3'b011, 5, 5, 0);
    tick(4);
    checkOutput("ena_freeze", b0.resulta, 64'd42);
    applyStimulus(0, 3'b111, 5, 5, 0);
    tick(1);
    checkOutput("ena_release", b0.resulta, 64'd25);

    // Clear pulse mid-stream
    applyStimulus(0, 3'b111, 4, 4, 0);
    tick(3);
    checkOutput("clr_before", b0.resulta, 64'd16);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checkOutput("clr_zero", b0.resulta, 64'd0);
    tick(2);
    checkOutput("clr_cycle2", b0.resulta, 64'd0);
    tick(1);
    checkOutput("clr_cycle3", b0.resulta, 64'd16);

    // Latency sweep: (0,0) -> 2 cycles, (1,1) -> 4 cycles
    applyStimulus(2, 3'b111, 9, 3, 0);
    applyStimulus(3, 3'b111, 9, 3, 0);
    tick(1);
    checkOutput("p00_cycle1", b2.resulta, 64'd0);
    tick(1);
    checkOutput("p00_cycle2", b2.resulta, 64'd27);
    checkOutput("p11_cycle2", b3.resulta, 64'd0);
    tick(1);
    checkOutput("p11_cycle3", b3.resulta, 64'd0);
    tick(1);
    checkOutput("p11_cycle4", b3.resulta, 64'd27);

    // Four-slice chain, operands 1..4 times 1
    first0 = -1;
    first3 = -1;
    chain_go = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick(1);
      if (first0 < 0 && ci[0].resulta == 64'd1) first0 = cyc;
      if (first3 < 0 && ci[3].resulta == 64'd10) first3 = cyc;
    end
    checkOutput("chain4_slice0_cycle", 64'(first0), 64'd2);
    checkOutput("chain4_skew", 64'(first3 - first0), 64'd3);
    checkOutput("chain4_sum", ci[3].resulta, 64'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
